// File: rtl/shop.sv
// Command-driven shop database: user accounts and item stock behind an ASCII command port.
// Optional SHOP_BUY_CNT_EN adds o_buys, a saturating count of successful purchases.
module shop #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int I_A_NUM_BITS        = 8 * I_A_NUM_ASCII_CHARS,
    parameter int I_U_NUM_BITS        = 4,
    parameter int O_A_NUM_ASCII_CHARS = 9,
    parameter int O_A_NUM_BITS        = 8 * O_A_NUM_ASCII_CHARS,
    parameter int MAX_USERS           = 5,
    parameter int MAX_ITEMS           = 8,
    parameter logic [I_A_NUM_BITS-1:0] ADMIN_PW = I_A_NUM_BITS'("admin")
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_rdy,
    input  logic [I_U_NUM_BITS-1:0] i_u,
    input  logic [I_A_NUM_BITS-1:0] i_a,
    output logic [O_A_NUM_BITS-1:0] o_a
`ifdef SHOP_BUY_CNT_EN
    ,
    output logic [15:0]             o_buys
`endif
);
    localparam int UW = $clog2(MAX_USERS);
    localparam int IW = $clog2(MAX_ITEMS);
    localparam logic [I_U_NUM_BITS-1:0] U_MAX = I_U_NUM_BITS'(MAX_USERS);

    localparam logic [I_A_NUM_BITS-1:0] K_LOGOUT  = I_A_NUM_BITS'("Logout");
    localparam logic [I_A_NUM_BITS-1:0] K_LOGIN   = I_A_NUM_BITS'("Login");
    localparam logic [I_A_NUM_BITS-1:0] K_ADDUSR  = I_A_NUM_BITS'("AddUsr");
    localparam logic [I_A_NUM_BITS-1:0] K_DELUSR  = I_A_NUM_BITS'("DelUsr");
    localparam logic [I_A_NUM_BITS-1:0] K_ADDITEM = I_A_NUM_BITS'("AddItem");
    localparam logic [I_A_NUM_BITS-1:0] K_DELITEM = I_A_NUM_BITS'("DelItem");
    localparam logic [I_A_NUM_BITS-1:0] K_BUY     = I_A_NUM_BITS'("Buy");

    localparam logic [O_A_NUM_BITS-1:0] R_CMD    = O_A_NUM_BITS'("Cmd?");
    localparam logic [O_A_NUM_BITS-1:0] R_OK     = O_A_NUM_BITS'("OK");
    localparam logic [O_A_NUM_BITS-1:0] R_ARG    = O_A_NUM_BITS'("Arg?");
    localparam logic [O_A_NUM_BITS-1:0] R_BADCMD = O_A_NUM_BITS'("BadCmd");
    localparam logic [O_A_NUM_BITS-1:0] R_DENIED = O_A_NUM_BITS'("Denied");
    localparam logic [O_A_NUM_BITS-1:0] R_NOUSER = O_A_NUM_BITS'("NoUser");
    localparam logic [O_A_NUM_BITS-1:0] R_EXISTS = O_A_NUM_BITS'("Exists");
    localparam logic [O_A_NUM_BITS-1:0] R_FULL   = O_A_NUM_BITS'("Full");
    localparam logic [O_A_NUM_BITS-1:0] R_NOITEM = O_A_NUM_BITS'("NoItem");

    typedef enum logic [2:0] {
        S_CMD, S_LOGIN, S_ADDUSR, S_DELUSR, S_ADDITEM, S_DELITEM, S_BUY
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic                      r_rdy;
    logic [O_A_NUM_BITS-1:0]   r_oa, w_resp;
    logic                      r_logged;
    logic [I_U_NUM_BITS-1:0]   r_uid;
    logic                      r_uvalid [MAX_USERS];
    logic [I_A_NUM_BITS-1:0]   r_upw    [MAX_USERS];
    logic [I_A_NUM_BITS-1:0]   r_name   [MAX_ITEMS];
    logic [7:0]                r_cnt    [MAX_ITEMS];

    logic          w_evt, w_admin, w_known, w_u_in;
    logic [UW-1:0] w_uidx;
    logic          w_hit, w_free;
    logic [IW-1:0] w_hit_idx, w_free_idx;
    logic          w_login, w_logout, w_uadd, w_udel;
    logic          w_iinc, w_inew, w_idel, w_idec;

    assign w_evt   = i_rdy && !r_rdy;
    assign w_admin = r_logged && (r_uid == '0);
    assign w_u_in  = i_u < U_MAX;
    assign w_uidx  = i_u[UW-1:0];
    assign w_known = (i_a == K_LOGOUT) || (i_a == K_LOGIN) ||
                     (i_a == K_ADDUSR) || (i_a == K_DELUSR) ||
                     (i_a == K_ADDITEM) || (i_a == K_DELITEM) ||
                     (i_a == K_BUY);
    assign o_a     = r_oa;

    // Item lookup: slot holding i_a, and lowest empty slot.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int k = MAX_ITEMS - 1; k >= 0; k--) begin
            if (r_cnt[k] != 8'd0 && r_name[k] == i_a) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(k);
            end
            if (r_cnt[k] == 8'd0) begin
                w_free     = 1'b1;
                w_free_idx = IW'(k);
            end
        end
    end

    // State register; reset aborts any pending argument.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_CMD;
        else          r_state <= w_state_nxt;
    end

    // Next state: commands open an argument state, arguments return to CMD.
    always_comb begin
        w_state_nxt = r_state;
        if (w_evt) begin
            w_state_nxt = S_CMD;
            if (r_state == S_CMD) begin
                unique case (1'b1)
                    (i_a == K_LOGIN):   w_state_nxt = S_LOGIN;
                    (i_a == K_ADDUSR):  if (w_admin)  w_state_nxt = S_ADDUSR;
                    (i_a == K_DELUSR):  if (w_admin)  w_state_nxt = S_DELUSR;
                    (i_a == K_ADDITEM): if (r_logged) w_state_nxt = S_ADDITEM;
                    (i_a == K_DELITEM): if (r_logged) w_state_nxt = S_DELITEM;
                    (i_a == K_BUY):     if (r_logged) w_state_nxt = S_BUY;
                    default:            w_state_nxt = S_CMD;
                endcase
            end
        end
    end

    // Response word and table update strobes for the current event.
    always_comb begin
        w_resp   = r_oa;
        w_login  = 1'b0;
        w_logout = 1'b0;
        w_uadd   = 1'b0;
        w_udel   = 1'b0;
        w_iinc   = 1'b0;
        w_inew   = 1'b0;
        w_idel   = 1'b0;
        w_idec   = 1'b0;
        if (w_evt) begin
            unique case (r_state)
                S_CMD: begin
                    if (i_a == K_LOGOUT) begin
                        w_resp   = R_OK;
                        w_logout = 1'b1;
                    end else if (w_state_nxt != S_CMD) w_resp = R_ARG;
                    else if (w_known)                  w_resp = R_DENIED;
                    else                               w_resp = R_BADCMD;
                end
                S_LOGIN: begin
                    if (w_u_in && r_uvalid[w_uidx] && r_upw[w_uidx] == i_a) begin
                        w_resp  = R_OK;
                        w_login = 1'b1;
                    end else begin
                        w_resp   = R_DENIED;
                        w_logout = 1'b1;
                    end
                end
                S_ADDUSR: begin
                    if (!w_u_in || i_u == '0) w_resp = R_NOUSER;
                    else if (r_uvalid[w_uidx]) w_resp = R_EXISTS;
                    else begin
                        w_resp = R_OK;
                        w_uadd = 1'b1;
                    end
                end
                S_DELUSR: begin
                    if (i_u == '0) w_resp = R_DENIED;
                    else if (!w_u_in || !r_uvalid[w_uidx]) w_resp = R_NOUSER;
                    else begin
                        w_resp = R_OK;
                        w_udel = 1'b1;
                    end
                end
                S_ADDITEM: begin
                    if (w_hit) begin
                        if (r_cnt[w_hit_idx] == 8'hFF) w_resp = R_FULL;
                        else begin
                            w_resp = R_OK;
                            w_iinc = 1'b1;
                        end
                    end else if (w_free) begin
                        w_resp = R_OK;
                        w_inew = 1'b1;
                    end else w_resp = R_FULL;
                end
                S_DELITEM: begin
                    w_resp = w_hit ? R_OK : R_NOITEM;
                    w_idel = w_hit;
                end
                S_BUY: begin
                    w_resp = w_hit ? R_OK : R_NOITEM;
                    w_idec = w_hit;
                end
                default: w_resp = r_oa;
            endcase
        end
    end

    // Strobe edge detector and registered status word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rdy <= 1'b0;
            r_oa  <= R_CMD;
        end else begin
            r_rdy <= i_rdy;
            if (w_evt) r_oa <= w_resp;
        end
    end

    // Session: who is logged in.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_logged <= 1'b0;
            r_uid    <= '0;
        end else if (w_login) begin
            r_logged <= 1'b1;
            r_uid    <= i_u;
        end else if (w_logout) begin
            r_logged <= 1'b0;
            r_uid    <= '0;
        end
    end

    // User table; slot 0 is the permanent admin account.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < MAX_USERS; k++) begin
                r_uvalid[k] <= (k == 0);
                r_upw[k]    <= (k == 0) ? ADMIN_PW : '0;
            end
        end else if (w_uadd) begin
            r_uvalid[w_uidx] <= 1'b1;
            r_upw[w_uidx]    <= i_a;
        end else if (w_udel) begin
            r_uvalid[w_uidx] <= 1'b0;
        end
    end

    // Item table; a zero count marks a free slot.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < MAX_ITEMS; k++) begin
                r_name[k] <= '0;
                r_cnt[k]  <= 8'd0;
            end
        end else if (w_inew) begin
            r_name[w_free_idx] <= i_a;
            r_cnt[w_free_idx]  <= 8'd1;
        end else if (w_iinc) begin
            r_cnt[w_hit_idx] <= r_cnt[w_hit_idx] + 8'd1;
        end else if (w_idec) begin
            r_cnt[w_hit_idx] <= r_cnt[w_hit_idx] - 8'd1;
        end else if (w_idel) begin
            r_cnt[w_hit_idx] <= 8'd0;
        end
    end

`ifdef SHOP_BUY_CNT_EN
    logic [15:0] r_buys;
    assign o_buys = r_buys;

    // Saturating count of successful purchases.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)                      r_buys <= 16'd0;
        else if (w_idec && r_buys != 16'hFFFF) r_buys <= r_buys + 16'd1;
    end
`else
    // Purchase counter not built.
`endif

endmodule

// File: tb/tb_shop.sv
// Scoreboard bench for shop: expected status words queued at each strobe,
// checked when the DUT answers.
module tb_shop;
    typedef logic [55:0] a_t;
    typedef logic [71:0] o_t;

    logic       i_clk;
    logic       i_reset;
    logic       i_rdy;
    logic [3:0] i_u;
    a_t         i_a;
    o_t         o_a;
`ifdef SHOP_BUY_CNT_EN
    logic [15:0] o_buys;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    o_t q[$];

    shop dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_rdy   (i_rdy),
        .i_u     (i_u),
        .i_a     (i_a),
        .o_a     (o_a)
`ifdef SHOP_BUY_CNT_EN
        ,
        .o_buys  (o_buys)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input o_t got, input o_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got \"%0s\" (%h) want \"%0s\" (%h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        o_t e;
        if (q.size() == 0) begin
            chk({tag, " empty-queue"}, o_a, '1);
        end else begin
            e = q.pop_front();
            chk(tag, o_a, e);
        end
    endtask

    task automatic send(input string tag, input logic [3:0] u,
                        input a_t a, input o_t exp);
        i_u   = u;
        i_a   = a;
        i_rdy = 1'b1;
        q.push_back(exp);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rdy = 1'b0;
        pop_chk(tag);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        a_t nm;
        i_reset = 1'b0;
        i_rdy   = 1'b0;
        i_u     = '0;
        i_a     = '0;
        @(negedge i_clk);
        do_reset();
        chk("reset", o_a, 72'("Cmd?"));
`ifdef SHOP_BUY_CNT_EN
        chk("buys_reset", 72'(o_buys), 72'd0);
`endif
        send("badcmd", 0, 56'("sdfsdf"), 72'("BadCmd"));
        send("add_out", 0, 56'("AddItem"), 72'("Denied"));
        send("login", 0, 56'("Login"), 72'("Arg?"));
        send("login_adm", 0, 56'("admin"), 72'("OK"));

        send("add1", 0, 56'("AddItem"), 72'("Arg?"));
        send("add1_pen", 0, 56'("pen"), 72'("OK"));
        send("add2", 0, 56'("AddItem"), 72'("Arg?"));
        send("add2_pen", 0, 56'("pen"), 72'("OK"));
        for (int k = 0; k < 3; k++) begin
            send("buy", 0, 56'("Buy"), 72'("Arg?"));
            send("buy_pen", 0, 56'("pen"), (k < 2) ? 72'("OK") : 72'("NoItem"));
        end
`ifdef SHOP_BUY_CNT_EN
        chk("buys_two", 72'(o_buys), 72'd2);
`endif

        send("addusr", 0, 56'("AddUsr"), 72'("Arg?"));
        send("addusr_2", 2, 56'("pw"), 72'("OK"));
        send("addusr", 0, 56'("AddUsr"), 72'("Arg?"));
        send("addusr_dup", 2, 56'("pw"), 72'("Exists"));
        send("addusr", 0, 56'("AddUsr"), 72'("Arg?"));
        send("addusr_7", 7, 56'("x"), 72'("NoUser"));
        send("login", 0, 56'("Login"), 72'("Arg?"));
        send("login_bad", 2, 56'("bad"), 72'("Denied"));
        send("add_after_bad", 0, 56'("AddItem"), 72'("Denied"));

        send("login", 0, 56'("Login"), 72'("Arg?"));
        send("login_u2", 2, 56'("pw"), 72'("OK"));
        send("u2_addusr", 0, 56'("AddUsr"), 72'("Denied"));
        send("u2_add", 0, 56'("AddItem"), 72'("Arg?"));
        send("u2_add_pen", 0, 56'("pen"), 72'("OK"));
        send("logout", 0, 56'("Logout"), 72'("OK"));
        send("add_logged_out", 0, 56'("AddItem"), 72'("Denied"));

        send("login", 0, 56'("Login"), 72'("Arg?"));
        send("login_adm", 0, 56'("admin"), 72'("OK"));
        for (int k = 0; k < 8; k++) begin
            nm = {40'd0, 8'h69, 8'(48 + k)};
            send("fill", 0, 56'("AddItem"), 72'("Arg?"));
            send("fill_item", 0, nm, (k < 7) ? 72'("OK") : 72'("Full"));
        end
        send("add_exist", 0, 56'("AddItem"), 72'("Arg?"));
        send("add_exist_pen", 0, 56'("pen"), 72'("OK"));
        send("del", 0, 56'("DelItem"), 72'("Arg?"));
        send("del_unknown", 0, 56'("zz"), 72'("NoItem"));
        send("del", 0, 56'("DelItem"), 72'("Arg?"));
        send("del_i3", 0, 56'("i3"), 72'("OK"));
        send("reuse", 0, 56'("AddItem"), 72'("Arg?"));
        send("reuse_i7", 0, 56'("i7"), 72'("OK"));
        send("full2", 0, 56'("AddItem"), 72'("Arg?"));
        send("full2_i9", 0, 56'("i9"), 72'("Full"));

        send("delusr", 0, 56'("DelUsr"), 72'("Arg?"));
        send("delusr_0", 0, 56'("x"), 72'("Denied"));
        send("delusr", 0, 56'("DelUsr"), 72'("Arg?"));
        send("delusr_2", 2, 56'("x"), 72'("OK"));
        send("delusr", 0, 56'("DelUsr"), 72'("Arg?"));
        send("delusr_2again", 2, 56'("x"), 72'("NoUser"));
        send("login", 0, 56'("Login"), 72'("Arg?"));
        send("login_deleted", 2, 56'("pw"), 72'("Denied"));

        send("login", 0, 56'("Login"), 72'("Arg?"));
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("reset_mid", o_a, 72'("Cmd?"));
        i_reset = 1'b1;
        @(negedge i_clk);
`ifdef SHOP_BUY_CNT_EN
        chk("buys_after_reset", 72'(o_buys), 72'd0);
`endif
        send("after_reset", 0, 56'("hi"), 72'("BadCmd"));
        send("after_reset_add", 0, 56'("AddItem"), 72'("Denied"));

        i_u   = 0;
        i_a   = 56'("Login");
        i_rdy = 1'b1;
        q.push_back(72'("Arg?"));
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rdy = 1'b0;
        pop_chk("held_rdy");
        @(negedge i_clk);
        send("held_then_pw", 0, 56'("admin"), 72'("OK"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
